uio_bus_arbiter: RTL and testbench

Round-robin arbiter that shares the bidirectional uio pad bus of tt_um_luis between up to N_REQ internal requesters (FSM core, debug/readback, pattern generator, ...). It grants one owner at a time and drives the bus output-enable while a grant is active. It bounds ownership with a hold timeout and inserts turnaround cycles between owners so that no two drivers overlap. It sits between the requesting sub-blocks and the uio_out/uio_oe muxing in the top level.

---
 rtl/uio_bus_arbiter.sv | 143 ++++++++++++++
 tb/tb_uio_bus_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uio_bus_arbiter.sv
// ============================================================================
// Module   : uio_bus_arbiter
// Purpose  : Round-robin owner arbiter for the shared uio pad bus, with a hold
//            timeout and turnaround dead cycles between owners.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uio_bus_arbiter #(
  parameter int N_REQ     = 4,
  parameter int MAX_HOLD  = 15,
  parameter int TA_CYCLES = 1,
  localparam int IDW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] rel,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             bus_oe,
  output logic             timeout,
  output logic             busy
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int TW = (TA_CYCLES > 1) ? $clog2(TA_CYCLES) : 1;
  localparam logic [HW-1:0] C_HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [TW-1:0] C_TA_LAST   = TW'(TA_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT      = 2'd1,
    TURNAROUND = 2'd2
  } state_t;

  state_t           r_state,   w_state_nxt;
  logic [N_REQ-1:0] r_gnt,     w_gnt_nxt;
  logic [IDW-1:0]   r_gnt_id,  w_gnt_id_nxt;
  logic             r_timeout, w_timeout_nxt;
  logic [IDW-1:0]   r_rr_ptr,  w_rr_ptr_nxt;
  logic [HW-1:0]    r_hold,    w_hold_nxt;
  logic [TW-1:0]    r_ta,      w_ta_nxt;

  logic             w_found;
  logic [IDW-1:0]   w_sel;
  logic             w_own_rel;
  logic             w_own_req;
  logic             w_hold_hit;
  logic [IDW-1:0]   w_next_ptr;

  // First requester at or above rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int j;
    w_found = 1'b0;
    w_sel   = '0;
    j       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(r_rr_ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!w_found && req[j]) begin
        w_found = 1'b1;
        w_sel   = IDW'(j);
      end
    end
  end

  assign w_own_rel  = rel[r_gnt_id];
  assign w_own_req  = req[r_gnt_id];
  assign w_hold_hit = (r_hold == C_HOLD_LAST);
  assign w_next_ptr = (int'(r_gnt_id) == N_REQ - 1) ? '0 : r_gnt_id + IDW'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_timeout_nxt = 1'b0;
    w_rr_ptr_nxt  = r_rr_ptr;
    w_hold_nxt    = r_hold;
    w_ta_nxt      = r_ta;
    case (r_state)
      IDLE: begin
        if (ena && w_found) begin
          w_state_nxt  = GRANT;
          w_gnt_nxt    = N_REQ'(1) << w_sel;
          w_gnt_id_nxt = w_sel;
          w_hold_nxt   = '0;
        end
      end
      GRANT: begin
        w_hold_nxt = r_hold + HW'(1);
        if (w_own_rel || !w_own_req || !ena || w_hold_hit) begin
          w_state_nxt   = TURNAROUND;
          w_gnt_nxt     = '0;
          w_gnt_id_nxt  = '0;
          w_rr_ptr_nxt  = w_next_ptr;
          w_ta_nxt      = '0;
          // A voluntary release on the limit edge is not a timeout.
          w_timeout_nxt = w_hold_hit && !w_own_rel;
        end
      end
      TURNAROUND: begin
        w_ta_nxt = r_ta + TW'(1);
        if (r_ta == C_TA_LAST) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt  = IDLE;
        w_gnt_nxt    = '0;
        w_gnt_id_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_timeout <= 1'b0;
      r_rr_ptr  <= '0;
      r_hold    <= '0;
      r_ta      <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_timeout <= w_timeout_nxt;
      r_rr_ptr  <= w_rr_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_ta      <= w_ta_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign bus_oe  = |r_gnt;
  assign timeout = r_timeout;
  assign busy    = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uio_bus_arbiter.sv
// ============================================================================
// Module   : tb_uio_bus_arbiter
// Purpose  : Directed self-checking bench for uio_bus_arbiter (defaults).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uio_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [3:0] req;
  logic [3:0] rel;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       bus_oe;
  logic       timeout;
  logic       busy;

  int n_vec;
  int n_err;

  uio_bus_arbiter #(.N_REQ(4), .MAX_HOLD(15), .TA_CYCLES(1)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .bus_oe  (bus_oe),
    .timeout (timeout),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; inputs set afterwards hit the following edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input int id);
    check({tag, ".gnt"},    32'(gnt),    32'(1) << id);
    check({tag, ".gnt_id"}, 32'(gnt_id), 32'(id));
    check({tag, ".bus_oe"}, 32'(bus_oe), 32'd1);
  endtask

  task automatic check_idle_bus(input string tag);
    check({tag, ".gnt"},    32'(gnt),    32'd0);
    check({tag, ".gnt_id"}, 32'(gnt_id), 32'd0);
    check({tag, ".bus_oe"}, 32'(bus_oe), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    ena   = 1'b1;
    req   = 4'b0000;
    rel   = 4'b0000;

    // Reset
    repeat (3) step();
    check_idle_bus("rst");
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    step();
    check_idle_bus("post_rst");
    check("post_rst.busy", 32'(busy), 32'd0);

    // Single owner: grant 1 edge after req, release on rel[2]
    req = 4'b0100;
    step();
    check_grant("single", 2);
    check("single.busy", 32'(busy), 32'd1);
    repeat (3) step();
    check_grant("single.hold", 2);
    rel = 4'b0100;
    step();
    rel = 4'b0000;
    check_idle_bus("single.rel");
    check("single.rel.busy", 32'(busy), 32'd1);
    check("single.rel.timeout", 32'(timeout), 32'd0);
    step();
    check("single.ta_done.busy", 32'(busy), 32'd0);
    req = 4'b0000;
    step();
    check_idle_bus("single.idle");

    // rr_ptr is 3: requester 0 wins by wrap-around, then async reset mid-grant
    req = 4'b0001;
    step();
    check_grant("wrap", 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_bus("async_rst");
    check("async_rst.busy", 32'(busy), 32'd0);
    req = 4'b0000;
    step();
    rst_n = 1'b1;
    step();

    // Round-robin with all requesting; rr_ptr back to 0
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check_grant($sformatf("rr%0d", k), k % 4);
      step();
      check_grant($sformatf("rr%0d.hold", k), k % 4);
      rel = 4'b0001 << (k % 4);
      step();
      rel = 4'b0000;
      check_idle_bus($sformatf("rr%0d.gap1", k));
      step();
      check_idle_bus($sformatf("rr%0d.gap2", k));
    end
    req = 4'b0000;
    step();
    check("rr.end.busy", 32'(busy), 32'd0);

    // Timeout: rr_ptr=1, only req[0] at first so 0 is granted
    req = 4'b0001;
    step();
    check_grant("to", 0);
    req = 4'b0011;
    repeat (14) step();
    check_grant("to.last", 0);
    check("to.last.timeout", 32'(timeout), 32'd0);
    step();
    check_idle_bus("to.rel");
    check("to.pulse", 32'(timeout), 32'd1);
    step();
    check("to.pulse_end", 32'(timeout), 32'd0);
    step();
    check_grant("to.next", 1);
    rel = 4'b0010;
    step();
    rel = 4'b0000;
    req = 4'b0000;
    repeat (2) step();

    // ena drop: rr_ptr=2
    req = 4'b1111;
    step();
    check_grant("ena", 2);
    ena = 1'b0;
    step();
    check_idle_bus("ena.drop");
    check("ena.drop.timeout", 32'(timeout), 32'd0);
    repeat (3) step();
    check_idle_bus("ena.blocked");
    check("ena.blocked.busy", 32'(busy), 32'd0);
    ena = 1'b1;
    step();
    check_grant("ena.resume", 3);

    // Non-owner rel ignored; owner rel on the limit edge gives no timeout
    rel = 4'b0001;
    step();
    rel = 4'b0000;
    check_grant("nonowner", 3);
    repeat (13) step();
    check_grant("coinc.last", 3);
    rel = 4'b1000;
    step();
    rel = 4'b0000;
    check_idle_bus("coinc.rel");
    check("coinc.timeout", 32'(timeout), 32'd0);
    req = 4'b0000;
    step();
    check("coinc.timeout2", 32'(timeout), 32'd0);
    step();
    check("coinc.busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
